// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides: seven single-cycle ops plus an
// unsigned radix-2 shift-add multiplier that occupies the block for WIDTH cycles.
module alu_pipe #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             busy
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {S_IDLE, S_MULT} state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [SHW-1:0]       r_cnt;

  logic [WIDTH-1:0]     r_result;
  logic                 r_cout;
  logic                 r_zero;
  logic                 r_neg;
  logic                 r_ovf;
  logic                 r_out_valid;

  logic                 w_accept;
  logic                 w_mul_last;
  logic [2*WIDTH-1:0]   w_acc_step;
  logic [WIDTH-1:0]     w_b_x;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH-1:0]     w_alu_res;
  logic                 w_alu_cout;
  logic                 w_alu_ovf;
  logic                 w_wr_en;
  logic [WIDTH-1:0]     w_wr_res;
  logic                 w_wr_cout;
  logic                 w_wr_ovf;

  assign w_accept   = in_valid && in_ready;
  assign w_mul_last = (r_state == S_MULT) && (r_cnt == SHW'(WIDTH - 1));
  assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state is always assigned with <= so every register samples
  // pre-edge values; blocking assignments here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: every signal driven in an always_comb gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept && op == OP_MUL) w_state_nxt = S_MULT;
      S_MULT: if (w_mul_last)               w_state_nxt = S_IDLE;
      default:                              w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready = (r_state == S_IDLE) && (!r_out_valid || out_ready);
    busy     = (r_state == S_MULT);
  end

  // ---------------- Single-cycle datapath ----------------
  assign w_b_x = (op == OP_SUB) ? ~b : b;
  assign w_sum = {1'b0, a} + {1'b0, w_b_x} + {{WIDTH{1'b0}}, (op == OP_SUB)};

  always_comb begin
    w_alu_res  = '0;
    w_alu_cout = 1'b0;
    w_alu_ovf  = 1'b0;
    case (op)
      OP_ADD: begin
        w_alu_res  = w_sum[WIDTH-1:0];
        w_alu_cout = w_sum[WIDTH];
        w_alu_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_res  = w_sum[WIDTH-1:0];
        w_alu_cout = w_sum[WIDTH];
        w_alu_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  w_alu_res = a & b;
      OP_OR:   w_alu_res = a | b;
      OP_XOR:  w_alu_res = a ^ b;
      OP_SLL:  w_alu_res = a << b[SHW-1:0];
      OP_SRL:  w_alu_res = a >> b[SHW-1:0];
      default: w_alu_res = '0;
    endcase
  end

  // A MUL finishes only while in_ready is low, so the two write sources never collide.
  assign w_wr_en   = (w_accept && op != OP_MUL) || w_mul_last;
  assign w_wr_res  = w_mul_last ? w_acc_step[WIDTH-1:0] : w_alu_res;
  assign w_wr_cout = w_mul_last ? (|w_acc_step[2*WIDTH-1:WIDTH]) : w_alu_cout;
  assign w_wr_ovf  = w_mul_last ? 1'b0 : w_alu_ovf;

  // ---------------- Multiplier iteration registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_accept && op == OP_MUL) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_MULT) begin
      r_acc    <= w_acc_step;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= w_mul_last ? '0 : r_cnt + 1'b1;
    end
  end

  // ---------------- Output slot ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result    <= '0;
      r_cout      <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_wr_en) begin
      r_result    <= w_wr_res;
      r_cout      <= w_wr_cout;
      r_zero      <= (w_wr_res == '0);
      r_neg       <= w_wr_res[WIDTH-1];
      r_ovf       <= w_wr_ovf;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign cout      = r_cout;
  assign zero      = r_zero;
  assign neg       = r_neg;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=32): hand-computed vectors covering
// flags, multiplier latency, back-to-back flow, backpressure and mid-MUL reset.
module tb_alu_pipe;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;
  logic             neg;
  logic             ovf;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;

  alu_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] t_op, input logic [WIDTH-1:0] t_a, input logic [WIDTH-1:0] t_b);
    in_valid = 1'b1;
    op       = t_op;
    a        = t_a;
    b        = t_b;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    op        = 3'b000;

    // Reset state
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_result",    result,    0);
    check("rst_flags",     {cout, zero, neg, ovf}, 0);
    check("rst_busy",      busy,      0);
    check("rst_in_ready",  in_ready,  1);
    rst_n = 1'b1;
    tick();

    // ADD 14 + 23
    drive(3'b000, 32'd14, 32'd23);
    tick();
    in_valid = 1'b0;
    check("add_result",    result,    37);
    check("add_cout",      cout,      0);
    check("add_zero",      zero,      0);
    check("add_out_valid", out_valid, 1);
    tick();
    check("add_valid_drop", out_valid, 0);

    // ADD wrap to zero, then SUB signed overflow
    drive(3'b000, 32'hFFFF_FFFF, 32'd1);
    tick();
    check("addw_result", result, 0);
    check("addw_cout",   cout,   1);
    check("addw_zero",   zero,   1);
    check("addw_ovf",    ovf,    0);
    drive(3'b001, 32'h8000_0000, 32'd1);
    tick();
    in_valid = 1'b0;
    check("sub_result", result, 32'h7FFF_FFFF);
    check("sub_ovf",    ovf,    1);
    check("sub_cout",   cout,   1);
    check("sub_neg",    neg,    0);
    tick();

    // MUL 1023 * 123: WIDTH-cycle latency with in_ready low throughout
    drive(3'b111, 32'd1023, 32'd123);
    tick();
    in_valid = 1'b0;
    check("mul1_busy_start", busy,     1);
    check("mul1_ready_low",  in_ready, 0);
    for (int i = 1; i < WIDTH; i++) begin
      tick();
      check($sformatf("mul1_busy_c%0d", i), {busy, in_ready, out_valid}, 3'b100);
    end
    tick();
    check("mul1_out_valid", out_valid, 1);
    check("mul1_result",    result,    125829);
    check("mul1_cout",      cout,      0);
    check("mul1_busy_end",  busy,      0);

    // MUL 0x10000 * 0x10000: low word 0, high word nonzero
    drive(3'b111, 32'h0001_0000, 32'h0001_0000);
    tick();
    in_valid = 1'b0;
    check("mul2_consumed", out_valid, 0);
    for (int i = 1; i < WIDTH; i++) tick();
    check("mul2_still_busy", busy, 1);
    tick();
    check("mul2_result",    result,    0);
    check("mul2_cout",      cout,      1);
    check("mul2_zero",      zero,      1);
    check("mul2_out_valid", out_valid, 1);

    // Back-to-back single-cycle ops
    drive(3'b100, 32'h0000_F0F0, 32'h0000_0FF0);
    tick();
    check("b2b_xor_valid", out_valid, 1);
    check("b2b_xor",       result,    32'h0000_FF00);
    drive(3'b101, 32'd1, 32'd35);
    tick();
    check("b2b_sll_valid", out_valid, 1);
    check("b2b_sll",       result,    8);
    drive(3'b110, 32'h80, 32'd4);
    tick();
    check("b2b_srl_valid", out_valid, 1);
    check("b2b_srl",       result,    8);
    drive(3'b011, 32'h0000_1200, 32'h0000_0034);
    tick();
    in_valid = 1'b0;
    check("b2b_or_valid", out_valid, 1);
    check("b2b_or",       result,    32'h1234);
    check("b2b_or_flags", {cout, ovf}, 0);
    tick();
    check("b2b_drain", out_valid, 0);

    // Backpressure: result holds while sink stalls
    out_ready = 1'b0;
    drive(3'b000, 32'd74, 32'd200);
    tick();
    check("bp_result",   result,   274);
    check("bp_in_ready", in_ready, 0);
    drive(3'b001, 32'd3, 32'd10);
    tick();
    check("bp_hold_result", result,    274);
    check("bp_hold_valid",  out_valid, 1);
    check("bp_hold_ready",  in_ready,  0);
    out_ready = 1'b1;
    #1;
    check("bp_ready_comb", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_swap_result", result,    32'hFFFF_FFF9);
    check("bp_swap_valid",  out_valid, 1);
    check("bp_swap_cout",   cout,      0);
    check("bp_swap_neg",    neg,       1);
    tick();
    check("bp_swap_drain", out_valid, 0);

    // Reset during MUL aborts it
    drive(3'b111, 32'd1023, 32'd123);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    check("mrst_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mrst_result", result, 0);
    check("mrst_flags",  {out_valid, cout, zero, neg, ovf, busy}, 0);
    check("mrst_ready",  in_ready, 1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < WIDTH + 2; i++) tick();
    check("mrst_no_output", out_valid, 0);
    drive(3'b000, 32'd141, 32'd243);
    tick();
    in_valid = 1'b0;
    check("mrst_add_result", result,    384);
    check("mrst_add_valid",  out_valid, 1);
    check("mrst_add_cout",   cout,      0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered successor to the combinational 32-bit ALU. It widens the operation set to eight ops, adds a signed flag set and a multi-cycle shift-add multiplier, and wraps everything in valid/ready handshakes on both sides. It sits between an operand source (sequencer or register-file read port) and a result sink, and provides backpressure in both directions.

## Interface
- WIDTH, 32, operand/result width; power of two, 8..64.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A (unsigned/two's complement per op).
- b  in  WIDTH  operand B.
- op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 MUL.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  sink consumes the result this cycle.
- result  out  WIDTH  registered result.
- cout  out  1  carry/no-borrow/unsigned-overflow flag.
- zero  out  1  result == 0.
- neg  out  1  result[WIDTH-1].
- ovf  out  1  signed overflow (ADD/SUB only, else 0).
- busy  out  1  multiplier FSM in MULT state.

## Operation
- Accept: a beat transfers on a rising edge with in_valid && in_ready. a, b and op are sampled only then; they are ignored otherwise.
- in_ready = (state == IDLE) && (!out_valid || out_ready). This is combinational from state, out_valid and out_ready only, never from in_valid.
- FSM states:
  - IDLE: accepting.
  - MULT: iterating.
- Transitions:
  - IDLE -> MULT on accept with op = MUL.
  - MULT -> IDLE when the iteration count reaches WIDTH-1 (the final iteration).
  - All other accepts stay in IDLE.
- Single-cycle ops write result and flags on the accept edge and set out_valid.
  - ADD: {cout, result} = a + b.
  - SUB: {cout, result} = a + ~b + 1, so cout = 1 means no borrow (a >= b unsigned).
  - ovf for ADD: a and b have equal sign and the result sign differs.
  - ovf for SUB: a and b have different sign and the result sign differs from a.
  - AND/OR/XOR: bitwise; cout = 0, ovf = 0.
  - SLL/SRL: logical shift of a by b[SHW-1:0]; upper bits of b are ignored; cout = 0, ovf = 0.
- MUL is unsigned, radix-2 shift-add, one multiplier bit per cycle.
  - result = low WIDTH bits of a*b.
  - cout = 1 if the high WIDTH bits are nonzero.
  - ovf = 0.
  - Internal registers: multiplicand (2*WIDTH), multiplier (WIDTH), accumulator (2*WIDTH), counter (SHW bits).
- zero and neg are always derived from the written result.
- out_valid clears on an edge with out_ready && out_valid, unless a new result is written on that same edge, in which case it stays 1.
- result and the flags hold their value until overwritten; they never change while out_valid = 1 && out_ready = 0.
- No accept occurs while in MULT (in_ready = 0). The output slot is always empty when a MUL result is written.

## Timing
- Reset (async assert, sync release): state = IDLE, out_valid = 0, result = 0, all flags = 0, busy = 0, counter = 0. in_ready is then 1.
- Single-cycle op accepted at edge N: out_valid = 1 with the result from edge N. Throughput is 1 beat/cycle while out_ready = 1.
- MUL accepted at edge N:
  - busy = 1 after edge N.
  - Iterations occur on edges N+1..N+WIDTH.
  - result is written and out_valid = 1 at edge N+WIDTH; busy = 0 after that edge.
  - Latency is WIDTH cycles. The next accept is possible at edge N+WIDTH+1 at the earliest.
- Simultaneous consume and accept on the same edge: the old result is dropped and the new one is written, with no bubble.
- Reset mid-MUL: the operation is aborted and nothing is output. After release the block behaves as if freshly reset.
- Counter wraps from WIDTH-1 to 0 at MULT exit.

## Test plan
- Reset, then ADD a=14, b=23, out_ready=1 -> next cycle result=37, cout=0, zero=0, out_valid=1 for exactly 1 cycle.
- ADD a=0xFFFFFFFF, b=1 -> result=0, cout=1, zero=1, ovf=0. Then SUB a=0x80000000, b=1 -> result=0x7FFFFFFF, ovf=1, cout=1.
- MUL a=1023, b=123 -> busy for 32 cycles, in_ready=0 throughout, result=125829 (0x1EB85), cout=0. Then MUL a=0x10000, b=0x10000 -> result=0, cout=1, zero=1.
- Back-to-back: 4 ops fed one per cycle (XOR, SLL a=1 b=35 -> 8, SRL a=0x80 b=4 -> 0x8, OR) with out_ready=1 -> 4 consecutive out_valid cycles, results in order.
- Backpressure: out_ready=0 after an ADD of 74+200 -> result holds 274, in_ready=0. Raise out_ready with a new beat presented -> consume and accept on the same edge.
- Assert rst_n low at the 10th MULT cycle of MUL 1023*123 -> all outputs 0 immediately, busy=0. After release, ADD 141+243 -> 384.
